// File: rtl/pool1_max2x2_stream_pkg.sv
// pool1_pkg: shared configuration for the pool-1 2x2/stride-2 max-pool stage.
//   Map geometry, channel packing, counter widths and the FSM state encoding.
//   Imported by the interface, the line buffer and the top.
package pool1_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int KERNAL_NUM = 6;
  localparam int IN_WIDTH   = 31;
  localparam int IN_HEIGHT  = 31;
  localparam int ADDR_WIDTH = 16;

  localparam int OUT_WIDTH  = IN_WIDTH / 2;
  localparam int OUT_HEIGHT = IN_HEIGHT / 2;

  localparam int BUS_W = DATA_WIDTH * KERNAL_NUM;
  localparam int COL_W = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
  localparam int ROW_W = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int LB_AW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_HEIGHT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pool_state_e;

endpackage

// File: rtl/pool1_max2x2_stream_if.sv
// pool1_max2x2_stream_if: bundles the conv-1 pixel stream and the pool-1
// DataBuf write port.
//   pool_1_out_en/pool_1_out_bus : pixel beat from conv-1 (master drives)
//   pool_wr_en/addr/data         : pooled pixel write strobe (slave drives)
//   frame_done                   : one-cycle end-of-frame pulse (slave drives)
//   busy                         : high while a frame is in progress (slave drives)
interface pool1_max2x2_stream_if;
  import pool1_pkg::*;

  logic                  pool_1_out_en;
  logic [BUS_W-1:0]      pool_1_out_bus;
  logic                  pool_wr_en;
  logic [ADDR_WIDTH-1:0] pool_wr_addr;
  logic [BUS_W-1:0]      pool_wr_data;
  logic                  frame_done;
  logic                  busy;

  modport master (
    output pool_1_out_en, pool_1_out_bus,
    input  pool_wr_en, pool_wr_addr, pool_wr_data, frame_done, busy
  );

  modport slave (
    input  pool_1_out_en, pool_1_out_bus,
    output pool_wr_en, pool_wr_addr, pool_wr_data, frame_done, busy
  );

endinterface

// File: rtl/pool1_max2x2_stream_line_buf.sv
// pool_line_buf: one-row buffer of horizontal pair maxima.
//   Synchronous write, asynchronous read so the vertical compare happens in
//   the same cycle as the odd-row beat and output latency stays one cycle.
//   clk   : clock
//   we    : write enable
//   waddr : write entry (col>>1)
//   wdata : packed pair-max channels
//   raddr : read entry (col>>1)
//   rdata : packed channels stored at raddr
module pool_line_buf
  import pool1_pkg::*;
#(
  parameter int DEPTH = OUT_WIDTH,
  parameter int WIDTH = BUS_W,
  parameter int AW    = LB_AW
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pool1_max2x2_stream.sv
// pool1_max2x2_stream: streaming 2x2 / stride-2 max-pool on conv-1 output.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   bus_if : slave side of pool1_max2x2_stream_if (pixel stream in,
//            DataBuf write port, frame_done, busy out)
// Optional build macro POOL1_RELU_CLAMP_EN: negative channel values are
// forced to 0 before any compare. Undefined: raw signed compare.
module pool1_max2x2_stream
  import pool1_pkg::*;
(
  input  logic clk,
  input  logic rst,
  pool1_max2x2_stream_if.slave bus_if
);

  function automatic logic signed [DATA_WIDTH-1:0] relu_clamp(
    input logic signed [DATA_WIDTH-1:0] v
  );
`ifdef POOL1_RELU_CLAMP_EN
    relu_clamp = v[DATA_WIDTH-1] ? '0 : v;
`else
    relu_clamp = v;
`endif
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    smax = (a >= b) ? a : b;
  endfunction

  pool_state_e           state_p0;
  logic [COL_W-1:0]      col_p0;
  logic [ROW_W-1:0]      row_p0;
  logic [ADDR_WIDTH-1:0] out_cnt_p0;
  logic                  pair_vld_p0;
  logic [BUS_W-1:0]      pair_p0;

  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [BUS_W-1:0]      data_p1;
  logic                  done_p1;
  logic                  busy_p1;

  logic [BUS_W-1:0]      in_bus;
  logic [BUS_W-1:0]      pmax_bus;
  logic [BUS_W-1:0]      win_bus;
  logic [BUS_W-1:0]      lb_rdata;
  logic [LB_AW-1:0]      lb_idx;

  logic beat, last_col, last_row, last_beat, lb_we, emit;

  assign beat      = bus_if.pool_1_out_en;
  assign last_col  = (col_p0 == COL_LAST);
  assign last_row  = (row_p0 == ROW_LAST);
  assign last_beat = beat & last_col & last_row;
  // Odd col closes a horizontal pair; in an odd-width map the last column is
  // even, so it is latched but never paired and drops out naturally.
  assign lb_we     = beat & pair_vld_p0 & col_p0[0] & ~row_p0[0];
  assign emit      = beat & pair_vld_p0 & col_p0[0] &  row_p0[0];
  assign lb_idx    = LB_AW'(col_p0 >> 1);

  for (genvar j = 0; j < KERNAL_NUM; j++) begin : g_ch
    assign in_bus[DATA_WIDTH*j +: DATA_WIDTH] =
      relu_clamp(bus_if.pool_1_out_bus[DATA_WIDTH*j +: DATA_WIDTH]);
    assign pmax_bus[DATA_WIDTH*j +: DATA_WIDTH] =
      smax(pair_p0[DATA_WIDTH*j +: DATA_WIDTH], in_bus[DATA_WIDTH*j +: DATA_WIDTH]);
    assign win_bus[DATA_WIDTH*j +: DATA_WIDTH] =
      smax(pmax_bus[DATA_WIDTH*j +: DATA_WIDTH], lb_rdata[DATA_WIDTH*j +: DATA_WIDTH]);
  end

  pool_line_buf u_line_buf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_idx),
    .wdata (pmax_bus),
    .raddr (lb_idx),
    .rdata (lb_rdata)
  );

  // Stage p0: raster counters, FSM, horizontal pair register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0    <= IDLE;
      busy_p1     <= 1'b0;
      col_p0      <= '0;
      row_p0      <= '0;
      out_cnt_p0  <= '0;
      pair_vld_p0 <= 1'b0;
    end else begin
      case (state_p0)
        IDLE: if (beat && !last_beat) begin
          state_p0 <= RUN;
          busy_p1  <= 1'b1;
        end
        RUN: if (last_beat) begin
          state_p0 <= IDLE;
          busy_p1  <= 1'b0;
        end
        default: begin
          state_p0 <= IDLE;
          busy_p1  <= 1'b0;
        end
      endcase

      if (beat) begin
        pair_vld_p0 <= ~col_p0[0];
        if (last_col) begin
          col_p0 <= '0;
          row_p0 <= last_row ? '0 : row_p0 + 1'b1;
        end else begin
          col_p0 <= col_p0 + 1'b1;
        end
        if (last_beat)  out_cnt_p0 <= '0;
        else if (emit)  out_cnt_p0 <= out_cnt_p0 + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat && !col_p0[0]) pair_p0 <= in_bus;
  end

  // Stage p1: registered write port and frame pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= emit;
      done_p1 <= last_beat;
      if (emit) begin
        addr_p1 <= out_cnt_p0;
        data_p1 <= win_bus;
      end
    end
  end

  assign bus_if.pool_wr_en   = vld_p1;
  assign bus_if.pool_wr_addr = addr_p1;
  assign bus_if.pool_wr_data = data_p1;
  assign bus_if.frame_done   = done_p1;
  assign bus_if.busy         = busy_p1;

endmodule

// File: doc/pool1_max2x2_stream.md
# pool1_max2x2_stream

Streaming 2×2 / stride-2 max-pool stage that sits on the receiving end of the conv-1 write interface. It accepts one pixel per beat, carrying all KERNAL_NUM ReLU outputs on a packed bus qualified by `pool_1_out_en`. It emits pooled pixels with a write address into the pool-1 DataBuf, which feeds conv-2. There is no backpressure: the block must sustain one input beat per clock.

## Interface
- DATA_WIDTH, 16: bits per channel value, signed two's complement.
- KERNAL_NUM, 6: channels per beat.
- IN_WIDTH, 31: conv-1 output map width.
- IN_HEIGHT, 31: conv-1 output map height.
- ADDR_WIDTH, 16: output address width.
- OUT_WIDTH, IN_WIDTH/2 (floor): derived.
- OUT_HEIGHT, IN_HEIGHT/2 (floor): derived.

- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pool_1_out_en  in  1  input beat valid; one pixel in raster order.
- pool_1_out_bus  in  DATA_WIDTH*KERNAL_NUM  channel j occupies bits [DATA_WIDTH*(j+1)-1 : DATA_WIDTH*j].
- pool_wr_en  out  1  pooled pixel valid; DataBuf write strobe.
- pool_wr_addr  out  ADDR_WIDTH  linear address, row*OUT_WIDTH+col.
- pool_wr_data  out  DATA_WIDTH*KERNAL_NUM  pooled channels, same packing as input.
- frame_done  out  1  one-cycle pulse at end of input frame.
- busy  out  1  high while in RUN.

## Operation
- **FSM states**
  - IDLE → RUN on the first `pool_1_out_en`. That beat is processed as pixel (0,0).
  - RUN → IDLE on the beat at (IN_HEIGHT-1, IN_WIDTH-1).
- **Counters**
  - `col`/`row` advance only on beats.
  - `col` wraps at IN_WIDTH-1 and then `row` increments.
  - Both counters clear to 0 on the last beat of the frame, so back-to-back frames need no idle cycle.
- **Pair register**
  - On even `col`, latch the beat.
  - On odd `col`, compute the per-channel max of the latched value and the current beat (signed compare; equal values keep either).
- **Even-row, odd-col beats:** write the pair max into the line buffer at entry `col>>1`.
- **Odd-row, odd-col beats:** take the per-channel max of the pair max and line-buffer entry `col>>1`, then emit.
  - `pool_wr_addr` = output counter, which increments per emitted pixel and clears at frame end.
- **Odd dimensions:** beats in the last column (col=IN_WIDTH-1 when IN_WIDTH is odd) and the last row (when IN_HEIGHT is odd) are consumed by the counters but never produce output.
- **Beat in IDLE during the same cycle as `frame_done`:** this starts the next frame normally.
- **Reset mid-frame:** all counters, the FSM and the pair valid state clear. Line-buffer contents are don't-care, because they are always rewritten before they are read.

## Timing
- Reset values: `pool_wr_en`=0, `pool_wr_addr`=0, `pool_wr_data`=0, `frame_done`=0, `busy`=0.
- Latency: input beat (odd row, odd col) at edge t gives `pool_wr_en`=1 at edge t+1. All outputs are registered.
- The line-buffer read is issued combinationally from `col>>1` or prefetched. Either way, output latency must stay exactly 1 cycle.
- `frame_done` is asserted at t+1 after the last frame beat, coincident with the last `pool_wr_en` only when both IN_WIDTH and IN_HEIGHT are even.
- Gaps (`pool_1_out_en`=0) are allowed anywhere. State holds and `pool_wr_en`=0 on those cycles.
- Throughput: 1 beat/cycle sustained. Maximum output rate is 1 per 2 cycles, during odd rows.

## Configuration
- `POOL1_RELU_CLAMP_EN` defined: each input channel value that is negative is forced to 0 before any compare. The block then guarantees non-negative outputs even if upstream ReLU is bypassed.
- Not defined: raw signed values are compared, and negative maxima propagate.

## Structure
- Shared package `pool1_pkg` holds:
  - DATA_WIDTH, KERNAL_NUM, IN_WIDTH, IN_HEIGHT;
  - derived OUT_WIDTH, OUT_HEIGHT;
  - FSM state encoding: IDLE=0, RUN=1.
- One sub-module, `pool_line_buf`: simple dual-port, OUT_WIDTH entries × DATA_WIDTH*KERNAL_NUM.
  - Synchronous write.
  - Read style is chosen to meet the 1-cycle latency.
- Channel max logic is a generate loop over KERNAL_NUM inside the top.

## Test plan
- **Ramp frame:** 31×31 frame with channel j value = row*31+col+j, continuous beats.
  - Expect 225 writes with addresses 0..224.
  - Address k=r*15+c carries (2r+1)*31+(2c+1)+j.
  - Then `frame_done` one cycle after the 961st beat.
- **Tie and negative values:** 2×2 window values {-5,-3,-3,-7} on channel 0.
  - Without macro: output -3.
  - With `POOL1_RELU_CLAMP_EN`: output 0.
- **Random gaps:** same ramp frame with 50% random `pool_1_out_en` gaps.
  - Expect identical data/address sequence.
  - Expect no `pool_wr_en` on gap-following cycles unless it is the registered response to the preceding qualifying beat.
- **Back-to-back frames:** two frames with no idle cycle between them.
  - Second frame addresses restart at 0.
  - `frame_done` pulses twice, 961 beats apart.
- **Reset mid-frame:** `rst` asserted after 500 beats, then a fresh full frame.
  - Outputs 0 during reset.
  - The fresh frame produces exactly 225 correct writes starting at address 0.
- **Dropped edge pixels:** large values placed only in column 30 and row 30 (e.g. 0x7FFF).
  - No output contains 0x7FFF.
